config_loader: RTL

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/config_loader.sv
// Serial configuration-chain loader: accepts host words over a valid/ready
// handshake and shifts CHAIN_LEN bits LSB-first into a downstream config chain.
module config_loader #(
  parameter int CHAIN_LEN = 40,
  parameter int WORD_W    = 32
) (
  input  logic              config_clk,
  input  logic              config_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              config_out,
  output logic              config_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BCW    = $clog2(CHAIN_LEN + 1);
  localparam int PW     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WCW    = $clog2(NWORDS + 1);

  localparam logic [BCW-1:0] LAST_BIT = BCW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0]  LAST_POS = PW'(WORD_W - 1);
  localparam logic [WCW-1:0] NW_C     = WCW'(NWORDS);

  typedef enum logic [2:0] {IDLE, WAIT_FIRST, SHIFT, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;

  always_ff @(posedge config_clk or posedge config_reset) begin
    if (config_reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      bit_cnt_q  <= '0;
      pos_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      bit_cnt_q  <= bit_cnt_d;
      pos_q      <= pos_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    bit_cnt_d  = bit_cnt_q;
    pos_d      = pos_q;
    word_cnt_d = word_cnt_q;
    word_ready = 1'b0;
    config_out = 1'b0;
    config_en  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        done  = (state_q == DONE);
        error = (state_q == ERR);
        if (start) begin
          state_d    = WAIT_FIRST;
          hold_vld_d = 1'b0;
          bit_cnt_d  = '0;
          pos_d      = '0;
          word_cnt_d = '0;
        end
      end
      WAIT_FIRST: begin
        busy       = 1'b1;
        word_ready = 1'b1;
        if (word_valid) begin
          shift_d    = word_in;
          word_cnt_d = WCW'(1);
          pos_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        busy       = 1'b1;
        config_out = shift_q[0];
        config_en  = 1'b1;
        word_ready = !hold_vld_q && (word_cnt_q < NW_C);
        bit_cnt_d  = bit_cnt_q + BCW'(1);
        if (word_ready && word_valid) begin
          hold_d     = word_in;
          hold_vld_d = 1'b1;
          word_cnt_d = word_cnt_q + WCW'(1);
        end
        // Underrun is judged on the holding register as it stood before this
        // edge, so a word landing on the boundary edge cannot rescue the load.
        if (bit_cnt_q == LAST_BIT) begin
          state_d = DONE;
        end else if (pos_q == LAST_POS) begin
          if (hold_vld_q) begin
            shift_d    = hold_q;
            hold_vld_d = 1'b0;
            pos_d      = '0;
          end else begin
            state_d = ERR;
          end
        end else begin
          shift_d = shift_q >> 1;
          pos_d   = pos_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
